// File: rtl/bitser_sequencer_pkg.sv
// Shared types and constants for the bit-serial CPU sequencer.
//   state_t       : sequencer FSM states
//   opcode_t      : 3-bit instruction opcode
//   OP_*          : opcode encodings
//   op_writes_reg : 1 when the opcode writes the result register
package bitser_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXEC      = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_NOP = 3'd0;
  localparam opcode_t OP_ADD = 3'd1;
  localparam opcode_t OP_SUB = 3'd2;
  localparam opcode_t OP_AND = 3'd3;
  localparam opcode_t OP_OR  = 3'd4;
  localparam opcode_t OP_XOR = 3'd5;
  localparam opcode_t OP_LDI = 3'd6;
  localparam opcode_t OP_HLT = 3'd7;

  // ADD..LDI produce a result; NOP and HLT never write.
  function automatic logic op_writes_reg(input opcode_t op);
    return (op >= OP_ADD) && (op <= OP_LDI);
  endfunction

endpackage

// File: rtl/bitser_sequencer_if.sv
// Control bundle between the pin wrapper / datapath and the sequencer.
//   master : side that drives ena/run/opcode and consumes the strobes
//   slave  : the sequencer itself
// Signals: ena, run, opcode (to sequencer); bit_idx, instr_shift_en,
// alu_shift_en, alu_first, alu_last, reg_we, pc_inc, busy, halted,
// retired (from sequencer).
interface bitser_sequencer_if #(
  parameter int CNT_W = 3
);
  import bitser_pkg::*;

  logic             ena;
  logic             run;
  opcode_t          opcode;
  logic [CNT_W-1:0] bit_idx;
  logic             instr_shift_en;
  logic             alu_shift_en;
  logic             alu_first;
  logic             alu_last;
  logic             reg_we;
  logic             pc_inc;
  logic             busy;
  logic             halted;
  logic [7:0]       retired;

  modport master (
    output ena, run, opcode,
    input  bit_idx, instr_shift_en, alu_shift_en, alu_first, alu_last,
           reg_we, pc_inc, busy, halted, retired
  );

  modport slave (
    input  ena, run, opcode,
    output bit_idx, instr_shift_en, alu_shift_en, alu_first, alu_last,
           reg_we, pc_inc, busy, halted, retired
  );

endinterface

// File: rtl/bitser_bit_counter.sv
// Bit-slot counter shared by FETCH and EXEC.
//   clk, rst_n : clock, async active-low reset
//   en         : advance one slot (wraps to 0 after WORD_W-1)
//   clr        : synchronous clear, dominates en
//   cnt        : current slot, LSB first
//   tc         : cnt is the last slot (WORD_W-1)
module bitser_bit_counter #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

  assign tc = (cnt == LAST);

  // Explicit wrap at tc so WORD_W need not be a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tc ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/bitser_sequencer.sv
// Fetch/decode/execute/writeback sequencer for the bit-serial core.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of bitser_sequencer_if (ena/run/opcode in,
//                shift enables, write/PC strobes, status, retired count out)
// Strobes are Moore decodes of state, bit slot and latched opcode, gated
// by ena so a frozen core never shifts or writes.
module bitser_sequencer
  import bitser_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 3
) (
  input logic                clk,
  input logic                rst_n,
  bitser_sequencer_if.slave  bus
);

  state_t           state;
  opcode_t          op_q;
  logic [7:0]       retired_q;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             in_slots;

  assign in_slots = (state == FETCH) || (state == EXEC);

  // Counter only moves in the slot states; held at 0 elsewhere so
  // bit_idx reads 0 in IDLE/DECODE/WRITEBACK/HALT.
  bitser_bit_counter #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.ena && in_slots),
    .clr   (bus.ena && !in_slots),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      retired_q <= '0;
    end else if (bus.ena) begin
      case (state)
        IDLE:      if (bus.run) state <= FETCH;
        FETCH:     if (tc) state <= DECODE;
        DECODE: begin
          op_q <= bus.opcode;
          case (bus.opcode)
            OP_HLT:  state <= HALT;
            OP_NOP:  state <= WRITEBACK;
            default: state <= EXEC;
          endcase
        end
        EXEC:      if (tc) state <= WRITEBACK;
        WRITEBACK: begin
          retired_q <= retired_q + 8'd1;
          state     <= bus.run ? FETCH : IDLE;
        end
        HALT:      if (!bus.run) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign bus.bit_idx        = cnt;
  assign bus.instr_shift_en = bus.ena && (state == FETCH);
  assign bus.alu_shift_en   = bus.ena && (state == EXEC);
  assign bus.alu_first      = bus.ena && (state == EXEC) && (cnt == '0);
  assign bus.alu_last       = bus.ena && (state == EXEC) && tc;
  assign bus.reg_we         = bus.ena && (state == WRITEBACK) && op_writes_reg(op_q);
  assign bus.pc_inc         = bus.ena && (state == WRITEBACK);
  assign bus.busy           = (state != IDLE) && (state != HALT);
  assign bus.halted         = (state == HALT);
  assign bus.retired        = retired_q;

endmodule
